mult_div_unit: RTL and testbench

- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits directly downstream of the instruction decoder and register file: decoder issues MULT/MULTU/DIV/DIVU/MTHI/MTLO with rs/rt read data; MFHI/MFLO read Hi/Lo combinationally through the register-write data mux.
- Radix-2 iterative, one bit per cycle; Busy drives the decoder's fetch stall.

---
 rtl/mult_div_unit_pkg.sv | 17 +
 rtl/mult_div_unit_cond_negate.sv | 11 +
 rtl/mult_div_unit.sv | 111 +++++++++++
 tb/tb_mult_div_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: op and state encodings shared by the multiply/divide unit.
package mult_div_unit_pkg;
    localparam int MD_WIDTH = 32;
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;
endpackage

// File: rtl/mult_div_unit_cond_negate.sv
// md_cond_negate: conditional two's-complement negate, used for operand magnitudes
// and for the sign fix-up of products, quotients and remainders.
module md_cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic             i_neg,
    input  logic [WIDTH-1:0] i_val,
    output logic [WIDTH-1:0] o_val
);
    assign o_val = i_neg ? -i_val : i_val;
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: radix-2 iterative multiply/divide with HI/LO registers.
// Signed ops iterate on magnitudes and correct the sign in a single FIX cycle.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int ITERS = WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_by_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int CW = $clog2(ITERS);

    md_state_e        r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc, r_q, r_m, r_hi, r_lo;
    logic             r_is_div, r_neg_res, r_neg_rem, r_done, r_dbz;

    logic             w_idle, w_signed, w_is_div, w_issue, w_dbz, w_go, w_neg_a, w_neg_b, w_ge;
    logic [WIDTH-1:0] w_abs_a, w_abs_b, w_q_fix, w_r_fix;
    logic [WIDTH:0]   w_sum, w_shift, w_diff;
    logic [2*WIDTH-1:0] w_prod_fix;

    assign w_idle   = r_state == ST_IDLE;
    assign w_signed = (i_op == MD_MULT) | (i_op == MD_DIV);
    assign w_is_div = (i_op == MD_DIV) | (i_op == MD_DIVU);
    assign w_issue  = i_start & w_idle & (w_signed | w_is_div | (i_op == MD_MULTU));
    assign w_dbz    = w_issue & w_is_div & (i_b == '0);
    assign w_go     = w_issue & ~w_dbz;
    assign w_neg_a  = w_signed & i_a[WIDTH-1];
    assign w_neg_b  = w_signed & i_b[WIDTH-1];

    md_cond_negate #(.WIDTH(WIDTH)) u_abs_a (.i_neg(w_neg_a), .i_val(i_a), .o_val(w_abs_a));
    md_cond_negate #(.WIDTH(WIDTH)) u_abs_b (.i_neg(w_neg_b), .i_val(i_b), .o_val(w_abs_b));
    md_cond_negate #(.WIDTH(WIDTH)) u_fix_q (.i_neg(r_neg_res), .i_val(r_q), .o_val(w_q_fix));
    md_cond_negate #(.WIDTH(WIDTH)) u_fix_r (.i_neg(r_neg_rem), .i_val(r_acc), .o_val(w_r_fix));
    md_cond_negate #(.WIDTH(2*WIDTH)) u_fix_p (.i_neg(r_neg_res), .i_val({r_acc, r_q}), .o_val(w_prod_fix));

    // Multiply: {acc,q} shifts right while adding m; divide: {acc,q} shifts left, trial-subtracting m.
    assign w_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
    assign w_shift = {r_acc, r_q[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_m};
    assign w_ge    = ~w_diff[WIDTH];

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = w_go ? ST_CALC : ST_IDLE;
            ST_CALC: w_next = (r_cnt == '0) ? ST_FIX : ST_CALC;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_m       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            r_done <= (r_state == ST_FIX) | w_dbz;
            r_dbz  <= w_dbz;
            if (w_go) begin
                r_cnt     <= CW'(ITERS - 1);
                r_acc     <= '0;
                r_q       <= w_is_div ? w_abs_a : w_abs_b;
                r_m       <= w_is_div ? w_abs_b : w_abs_a;
                r_is_div  <= w_is_div;
                r_neg_res <= w_neg_a ^ w_neg_b;
                r_neg_rem <= w_neg_a;
            end else if (r_state == ST_CALC) begin
                r_cnt <= r_cnt - CW'(1);
                r_acc <= r_is_div ? (w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0]) : w_sum[WIDTH:1];
                r_q   <= r_is_div ? {r_q[WIDTH-2:0], w_ge} : {w_sum[0], r_q[WIDTH-1:1]};
            end
            if (r_state == ST_FIX)
                {r_hi, r_lo} <= r_is_div ? {w_r_fix, w_q_fix} : w_prod_fix;
            else if (i_start && w_idle && i_op == MD_MTHI)
                r_hi <= i_a;
            else if (i_start && w_idle && i_op == MD_MTLO)
                r_lo <= i_a;
        end
    end

    assign o_busy        = ~w_idle;
    assign o_done        = r_done;
    assign o_div_by_zero = r_dbz;
    assign o_hi          = r_hi;
    assign o_lo          = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: transaction-level model checked every cycle, plus hand-computed
// result literals for each directed operation.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a_in = '0, b_in = '0;
    logic        busy, done, dbz;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_pass = 0;

    int          m_left;
    logic        m_done, m_dbz;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_pend;

    mult_div_unit dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op), .i_a(a_in), .i_b(b_in),
        .o_busy(busy), .o_done(done), .o_div_by_zero(dbz), .o_hi(hi), .o_lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference result as {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] f_op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, res;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        res = '0;
        case (f_op)
            3'd0: res = sa * sb;
            3'd1: res = ua * ub;
            3'd2: begin
                q = sa / sb;
                r = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            default: res = {a % b, a / b};
        endcase
        return res;
    endfunction

    // Model: 33 busy cycles after the accepting edge, then a Done cycle with new HI/LO.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            m_pend <= '0;
        end else begin
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    {m_hi, m_lo} <= m_pend;
                    m_done <= 1'b1;
                end
            end else if (start) begin
                if (op == 3'd4) m_hi <= a_in;
                else if (op == 3'd5) m_lo <= a_in;
                else if (op < 3'd4) begin
                    if (op[1] && b_in == 32'd0) begin
                        m_done <= 1'b1;
                        m_dbz  <= 1'b1;
                    end else begin
                        m_left <= 33;
                        m_pend <= ref_result(op, a_in, b_in);
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("cyc_busy", busy, m_left > 0);
        check("cyc_done", done, m_done);
        check("cyc_dbz", dbz, m_dbz);
        check("cyc_hi", hi, m_hi);
        check("cyc_lo", lo, m_lo);
    end

    // Called on a negedge; presents the op for the following rising edge.
    task automatic issue(input logic [2:0] t_op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op = t_op;
        a_in = a;
        b_in = b;
        @(negedge clk);
        start = 1'b0;
        a_in = $urandom;
        b_in = $urandom;
    endtask

    // Returns edges after the accepting edge until Done, and busy cycles seen.
    task automatic wait_done(output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        while (!done && lat < 60) begin
            if (busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        check("done_seen", done, 1'b1);
    endtask

    task automatic run(input string name, input logic [2:0] t_op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e_hi, input logic [31:0] e_lo);
        int lat, bn;
        issue(t_op, a, b);
        wait_done(lat, bn);
        check({name, "_hi"}, hi, e_hi);
        check({name, "_lo"}, lo, e_lo);
    endtask

    initial begin
        int lat, bn, seen;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(3'd0, 32'd7, 32'hFFFFFFFD);
        wait_done(lat, bn);
        check("mult_lat", lat, 33);
        check("mult_busy_cycles", bn, 33);
        check("mult_busy_in_done", busy, 1'b0);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFEB);

        run("multu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        issue(3'd3, 32'd100, 32'd7);
        wait_done(lat, bn);
        check("b2b_lat", lat, 33);
        check("divu_hi", hi, 32'd2);
        check("divu_lo", lo, 32'd14);

        run("div_neg7", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run("div_wrap", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        run("div_100_m7", 3'd2, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2);
        run("div_m100_7", 3'd2, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2);
        run("divu_big", 3'd3, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF);
        run("mult_min", 3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);

        issue(3'd4, 32'h11, 32'h0);
        issue(3'd5, 32'h22, 32'h0);
        check("mthi_val", hi, 32'h11);
        check("mtlo_val", lo, 32'h22);
        issue(3'd2, 32'd5, 32'd0);
        wait_done(lat, bn);
        check("dbz_lat", lat, 0);
        check("dbz_busy", bn, 0);
        check("dbz_flag", dbz, 1'b1);
        check("dbz_hi", hi, 32'h11);
        check("dbz_lo", lo, 32'h22);
        issue(3'd3, 32'd9, 32'd0);
        wait_done(lat, bn);
        check("dbzu_flag", dbz, 1'b1);

        issue(3'd4, 32'hDEADBEEF, 32'h0);
        check("mthi_hi", hi, 32'hDEADBEEF);
        check("mthi_nodone", done, 1'b0);
        check("mthi_nobusy", busy, 1'b0);
        issue(3'd6, 32'h5, 32'h5);
        check("nop_busy", busy, 1'b0);

        issue(3'd0, 32'd3, 32'd5);
        repeat (4) @(negedge clk);
        issue(3'd5, 32'h12345678, 32'h0);
        check("mtlo_busy_ignored", lo, 32'h22);
        wait_done(lat, bn);
        check("mult35_hi", hi, 32'h0);
        check("mult35_lo", lo, 32'd15);

        issue(3'd0, 32'd9, 32'd9);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort_no_done", seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
